// File: rtl/loader_pkg.sv
// loader_pkg: shared types and default sizes for the instruction loader.
//   loader_state_e : loader FSM states
//   LOADER_A       : default instruction address width
//   LOADER_W       : default instruction word width
package loader_pkg;

  localparam int unsigned LOADER_A = 12;
  localparam int unsigned LOADER_W = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } loader_state_e;

endpackage

// File: rtl/inst_loader.sv
// inst_loader: streams instruction words into the instruction memory write
// port while holding the CPU in reset, then verifies a trailing XOR checksum.
// Stream format: header low word, header high word, Count payload words,
// checksum word (XOR of payload words only).
//
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous active-high reset
//   Start      in   begin a load (honoured in IDLE or DONE only)
//   DataIn     in   [W] stream word
//   DataValid  in   DataIn valid
//   DataReady  out  word accepted this cycle when DataValid is high
//   WrEn       out  instruction memory write strobe (one cycle per word)
//   WrAddr     out  [A] instruction memory write address
//   WrData     out  [W] instruction memory write data
//   CpuHold    out  CPU held in reset while a load is in progress
//   Done       out  load finished (sticky until next accepted Start)
//   Error      out  checksum mismatch (meaningful while Done=1)
module inst_loader
  import loader_pkg::*;
#(
  parameter int unsigned A = LOADER_A,
  parameter int unsigned W = LOADER_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] DataIn,
  input  logic         DataValid,
  output logic         DataReady,
  output logic         WrEn,
  output logic [A-1:0] WrAddr,
  output logic [W-1:0] WrData,
  output logic         CpuHold,
  output logic         Done,
  output logic         Error
);

  // Counter and length carry one extra bit so a full-depth count is representable.
  localparam int unsigned CW = A + 1;

  loader_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          wr_en_q, wr_en_d;
  logic [A-1:0]  wr_addr_q, wr_addr_d;
  logic [W-1:0]  wr_data_q, wr_data_d;
  logic          err_q, err_d;
  logic          ready;
  logic          beat;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;

    ready = (state_q == HDR_LO) || (state_q == HDR_HI) ||
            (state_q == DATA)   || (state_q == CHECK);
    beat  = ready && DataValid;

    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = HDR_LO;
          cnt_d   = '0;
          acc_d   = '0;
          err_d   = 1'b0;
        end
      end
      HDR_LO: begin
        if (beat) begin
          len_d[W-1:0] = DataIn;
          state_d      = HDR_HI;
        end
      end
      HDR_HI: begin
        if (beat) begin
          len_d[A-1:W] = DataIn[A-W-1:0];
          // Zero-length decision uses the freshly assembled length.
          state_d = (len_d == '0) ? CHECK : DATA;
        end
      end
      DATA: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[A-1:0];
          wr_data_d = DataIn;
          acc_d     = acc_q ^ DataIn;
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == len_q - CW'(1)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (beat) begin
          err_d   = (DataIn != acc_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign DataReady = ready;
  assign WrEn      = wr_en_q;
  assign WrAddr    = wr_addr_q;
  assign WrData    = wr_data_q;
  // Decoded from state so an asynchronous Reset drops the hold immediately.
  assign CpuHold   = (state_q != IDLE) && (state_q != DONE);
  assign Done      = (state_q == DONE);
  assign Error     = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed self-checking bench for inst_loader.
module tb_inst_loader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [8:0]  DataIn = '0;
  logic        DataValid = 1'b0;
  logic        DataReady;
  logic        WrEn;
  logic [11:0] WrAddr;
  logic [8:0]  WrData;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  logic [11:0] wa[$];
  logic [8:0]  wd[$];
  int unsigned wc[$];
  int unsigned bc[$];

  inst_loader #(.A(12), .W(9)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .DataIn(DataIn),
    .DataValid(DataValid), .DataReady(DataReady), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .CpuHold(CpuHold),
    .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  // Inputs change at posedge+1, so negedge sees stable inputs and outputs.
  always @(negedge Clk) begin
    if (WrEn) begin
      wa.push_back(WrAddr);
      wd.push_back(WrData);
      wc.push_back(cyc);
    end
    if (DataValid && DataReady) bc.push_back(cyc);
    cyc++;
  end

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete(); bc.delete();
  endtask

  task automatic send_word(input logic [8:0] w);
    int unsigned n = 0;
    DataIn = w;
    DataValid = 1'b1;
    @(negedge Clk);
    while (!DataReady && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!DataReady) begin
      vectors++; miscompares++;
      $display("FAIL send_word_timeout: DataReady=%b required 1", DataReady);
    end
    @(posedge Clk); #1;
    DataValid = 1'b0;
  endtask

  task automatic do_start();
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle_cycles(3);
    vectors++;
    if ({DataReady, WrEn, WrAddr, WrData, CpuHold, Done, Error} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b required all 0",
               DataReady, WrEn, WrAddr, WrData, CpuHold, Done, Error);
    end
    Reset = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_basic();
    logic [8:0] exp_d[3] = '{9'h001, 9'h0F0, 9'h100};
    clear_logs();
    do_start();
    vectors++;
    if (CpuHold !== 1'b1 || DataReady !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_after_start: hold=%b rdy=%b required 1 1", CpuHold, DataReady);
    end
    send_word(9'd3); send_word(9'd0);
    send_word(9'h001); send_word(9'h0F0); send_word(9'h100);
    send_word(9'h1F1);
    vectors++;
    if (wa.size() != 3) begin
      miscompares++;
      $display("FAIL basic_write_count: got %0d required 3", wa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wa[i] !== 12'(i) || wd[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL basic_write%0d: addr=%h data=%h required %h %h", i, wa[i], wd[i], 12'(i), exp_d[i]);
        end
      end
    end
    vectors++;
    if (Done !== 1'b1 || Error !== 1'b0 || CpuHold !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: done=%b err=%b hold=%b required 1 0 0", Done, Error, CpuHold);
    end
  endtask

  task automatic test_bad_checksum();
    clear_logs();
    do_start();
    vectors++;
    if (Done !== 1'b0 || CpuHold !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_from_done: done=%b hold=%b required 0 1", Done, CpuHold);
    end
    send_word(9'd3); send_word(9'd0);
    send_word(9'h001); send_word(9'h0F0); send_word(9'h100);
    send_word(9'h000);
    vectors++;
    if (wa.size() != 3) begin
      miscompares++;
      $display("FAIL bad_write_count: got %0d required 3", wa.size());
    end
    vectors++;
    if (Done !== 1'b1 || Error !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_checksum_flag: done=%b err=%b required 1 1", Done, Error);
    end
    idle_cycles(2);
    vectors++;
    if (Error !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_error_sticky: err=%b required 1", Error);
    end
  endtask

  task automatic test_zero_length();
    clear_logs();
    do_start();
    vectors++;
    if (Error !== 1'b0) begin
      miscompares++;
      $display("FAIL error_cleared_by_start: err=%b required 0", Error);
    end
    send_word(9'd0); send_word(9'd0); send_word(9'h000);
    idle_cycles(2);
    vectors++;
    if (wa.size() != 0) begin
      miscompares++;
      $display("FAIL zero_len_writes: got %0d pulses required 0", wa.size());
    end
    vectors++;
    if (Done !== 1'b1 || Error !== 1'b0 || CpuHold !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_done: done=%b err=%b hold=%b required 1 0 0", Done, Error, CpuHold);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] pay[5] = '{9'h011, 9'h022, 9'h1AB, 9'h0C3, 9'h155};
    logic [8:0] x = '0;
    int unsigned bad = 0;
    clear_logs();
    do_start();
    send_word(9'd5); idle_cycles(1);
    send_word(9'd0); idle_cycles(1);
    for (int i = 0; i < 5; i++) begin
      send_word(pay[i]);
      x ^= pay[i];
      // Stall cycle with a Start pulse that must be ignored mid-load.
      Start = (i == 1 || i == 3);
      idle_cycles(1);
      Start = 1'b0;
    end
    vectors++;
    if (CpuHold !== 1'b1 || Done !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_start_ignored: hold=%b done=%b required 1 0", CpuHold, Done);
    end
    send_word(x);
    vectors++;
    if (wa.size() != 5 || bc.size() != 8) begin
      miscompares++;
      $display("FAIL bp_counts: writes=%0d beats=%0d required 5 8", wa.size(), bc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (wa[i] !== 12'(i) || wd[i] !== pay[i] || wc[i] != bc[i+2] + 1) bad++;
      end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL bp_write_timing: %0d bad writes required 0", bad);
      end
    end
    vectors++;
    if (Done !== 1'b1 || Error !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_done: done=%b err=%b required 1 0", Done, Error);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [8:0] pay[4] = '{9'h0AA, 9'h155, 9'h003, 9'h1C0};
    logic [8:0] x = '0;
    int unsigned bad = 0;
    do_start();
    send_word(9'd5); send_word(9'd0);
    send_word(9'h1FF); send_word(9'h0EE);
    Reset = 1'b1;
    #1;
    vectors++;
    if ({DataReady, WrEn, WrAddr, WrData, CpuHold, Done, Error} !== '0) begin
      miscompares++;
      $display("FAIL midload_reset: rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b required all 0",
               DataReady, WrEn, WrAddr, WrData, CpuHold, Done, Error);
    end
    idle_cycles(2);
    Reset = 1'b0;
    idle_cycles(1);
    clear_logs();
    do_start();
    send_word(9'd4); send_word(9'd0);
    for (int i = 0; i < 4; i++) begin
      send_word(pay[i]);
      x ^= pay[i];
    end
    send_word(x);
    vectors++;
    if (wa.size() != 4) begin
      miscompares++;
      $display("FAIL reload_write_count: got %0d required 4", wa.size());
    end else begin
      for (int i = 0; i < 4; i++) if (wa[i] !== 12'(i) || wd[i] !== pay[i]) bad++;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL reload_writes: %0d bad writes required 0", bad);
      end
    end
    vectors++;
    if (Done !== 1'b1 || Error !== 1'b0 || CpuHold !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_done: done=%b err=%b hold=%b required 1 0 0", Done, Error, CpuHold);
    end
  endtask

  task automatic test_max_size();
    logic [8:0] pay[$];
    logic [8:0] x = '0;
    int unsigned bad = 0;
    clear_logs();
    do_start();
    // 4095 = 0xFFF: low header word 0x1FF, high header word 0x7.
    send_word(9'h1FF); send_word(9'h007);
    for (int i = 0; i < 4095; i++) begin
      logic [8:0] w;
      w = 9'($urandom_range(0, 511));
      pay.push_back(w);
      x ^= w;
      send_word(w);
    end
    send_word(x);
    vectors++;
    if (wa.size() != 4095) begin
      miscompares++;
      $display("FAIL max_write_count: got %0d required 4095", wa.size());
    end else begin
      for (int i = 0; i < 4095; i++) if (wa[i] !== 12'(i) || wd[i] !== pay[i]) bad++;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL max_writes: %0d bad writes required 0", bad);
      end
      vectors++;
      if (wa[4094] !== 12'hFFE) begin
        miscompares++;
        $display("FAIL max_last_addr: got %h required ffe", wa[4094]);
      end
    end
    vectors++;
    if (Done !== 1'b1 || Error !== 1'b0) begin
      miscompares++;
      $display("FAIL max_done: done=%b err=%b required 1 0", Done, Error);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_bad_checksum();
    test_zero_length();
    test_backpressure();
    test_reset_mid_load();
    test_max_size();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Programs the instruction memory before execution. It accepts a stream of W-bit instruction words over a valid/ready handshake and writes them to sequential addresses through the instruction memory's write port. It holds the CPU in reset while loading and checks a trailing XOR checksum. It is the writer side of the instruction ROM: the ROM's contents at run time are exactly what this block wrote.

## Interface
Parameters:
- A, 12: instruction address width. Memory depth is 2**A.
- W, 9: instruction word width. Must be ≥ A-W+1 so the high header word fits (holds for defaults).

Ports:
- Clk, input, 1: the single clock; all state changes on its rising edge.
- Reset, input, 1: asynchronous, active-high.
- Start, input, 1: single-cycle request to begin a load. Honoured only in IDLE or DONE.
- DataIn, input, W: stream word (header, payload or checksum).
- DataValid, input, 1: DataIn is valid.
- DataReady, output, 1: loader accepts a word this cycle.
- WrEn, output, 1: instruction memory write strobe.
- WrAddr, output, A: instruction memory write address.
- WrData, output, W: instruction memory write data.
- CpuHold, output, 1: keeps the CPU in reset. High whenever the state is not IDLE or DONE.
- Done, output, 1: load finished. Sticky until the next accepted Start.
- Error, output, 1: checksum mismatch. Sticky until the next accepted Start. Valid only when Done=1.

## Operation
- Beat: DataValid && DataReady in the same cycle. DataReady is a combinational decode of state: 1 in HDR_LO, HDR_HI, DATA and CHECK; otherwise 0.
- IDLE: Start takes the block to HDR_LO, clears Done and Error, clears the address counter and clears the XOR accumulator.
- HDR_LO: a beat loads Count[W-1:0] and goes to HDR_HI.
- HDR_HI: a beat loads Count[A-1:W] from DataIn[A-W-1:0]; upper bits are ignored.
  - Count == 0: go to CHECK.
  - Otherwise: go to DATA.
- DATA: each beat does the following:
  - registers a write with WrAddr = counter and WrData = DataIn;
  - XORs DataIn into the accumulator;
  - increments the counter.
  - On the beat where counter == Count-1, the next state is CHECK.
- CHECK: a beat compares DataIn with the accumulator. Error is set if they differ. The next state is DONE.
- DONE: Done=1 and CpuHold=0. Start restarts the sequence exactly as from IDLE.
- Header words are not part of the checksum.
- Counter and Count are A+1 bits wide internally, so Count up to 2**A-1 needs no wrap handling. WrAddr = counter[A-1:0].
- Start in HDR_LO, HDR_HI, DATA or CHECK is ignored.
- DataValid outside a DataReady state is ignored. No data is consumed or dropped.

## Timing
- Reset values:
  - state IDLE;
  - DataReady=0, WrEn=0, WrAddr=0, WrData=0;
  - CpuHold=0, Done=0, Error=0;
  - counter, Count and accumulator all 0.
- Reset mid-load aborts immediately. Any partially written memory is left as is, and CpuHold drops asynchronously with Reset.
- Start accepted in cycle n: CpuHold=1 and DataReady=1 from cycle n+1.
- Write latency: a DATA beat in cycle n gives WrEn=1 with its WrAddr/WrData in cycle n+1, for exactly one cycle. Back-to-back beats give back-to-back writes.
- Throughput: one word per cycle. Minimum load time is Count+3 beats.
- CHECK beat in cycle n: Done=1, Error valid and CpuHold=0 in cycle n+1. The last memory write has completed by then.
- DataValid low stalls any state indefinitely, with no timeout.

## Structure
- Package loader_pkg holds:
  - typedef enum of states: IDLE, HDR_LO, HDR_HI, DATA, CHECK, DONE;
  - default A and W constants.
- Single module with no sub-modules. The XOR accumulator and counter are inline registers.

## Test plan
- Basic load: Start, then stream 3, 0, 0x001, 0x0F0, 0x100, 0x1F1.
  - Writes are addr0=0x001, addr1=0x0F0, addr2=0x100.
  - Afterwards Done=1, Error=0, CpuHold=0.
- Bad checksum: same stream with the last word 0x000. All 3 writes still occur, then Done=1 and Error=1.
- Zero length: Start, then 0, 0, 0x000. There are no WrEn pulses, and Done=1 with Error=0.
- Backpressure and stalls: payload with DataValid toggling every other cycle.
  - Writes occur only one cycle after each beat.
  - Addresses are contiguous from 0.
  - Start pulses during DATA are ignored.
- Reset mid-load: assert Reset after 2 of 5 payload beats.
  - All outputs return to their reset values immediately.
  - A following full load of 4 words starts again at addr 0 and completes cleanly.
- Max size: Count=4095 with random data and the correct checksum. The last write goes to addr 4095-1=0xFFE, then Done=1 and Error=0.
